// File: rtl/fetch_unit_pkg.sv
// Shared CPU front-end types: fetch FSM states, next-PC select codes and the reset vector.
// Used by fetch_unit (optionally built with FETCH_ADEL_EN) and fetch_pc_sel.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PcHold     = 2'd0,
    PcSeq      = 2'd1,
    PcRedirect = 2'd2
  } pc_sel_e;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC selection: a redirect always wins, otherwise step by one word when the
// held instruction is consumed, otherwise keep the current PC.
module fetch_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_next_o
);

  pc_sel_e sel;

  always_comb begin
    sel = PcHold;
    if (redirect_valid_i) begin
      sel = PcRedirect;
    end else if (advance_i) begin
      sel = PcSeq;
    end
  end

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel)
      PcRedirect: pc_next_o = redirect_pc_i;
      PcSeq:      pc_next_o = pc_i + PC_STEP;
      default:    pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: REQ/WAIT/HOLD handshake FSM with redirect and stale-response discard.
// Define FETCH_ADEL_EN to add the misaligned-PC address-error path and the out_adel port.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_ADEL_EN
  ,
  output logic        out_adel
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic         ireq_valid_q, ireq_valid_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
`ifdef FETCH_ADEL_EN
  logic         out_adel_q, out_adel_d;
`endif

  logic         advance;
  logic         req_accepted;

  assign advance      = (state_q == StHold) && out_ready;
  // A request only counts as accepted once it has actually been driven on the bus.
  assign req_accepted = ireq_valid_q && iresp_addr_ok;

  fetch_pc_sel u_pc_sel (
    .pc_i             (pc_q),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .advance_i        (advance),
    .pc_next_o        (pc_d)
  );

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
`ifdef FETCH_ADEL_EN
    out_adel_d  = out_adel_q;
`endif

    unique case (state_q)
      StReq: begin
        if (redirect_valid) begin
          if (req_accepted) begin
            discard_d = 1'b1;
            state_d   = StWait;
          end
`ifdef FETCH_ADEL_EN
        end else if (!pc_aligned(pc_q)) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          out_adel_d  = 1'b1;
          out_pc_d    = pc_q;
          out_instr_d = 32'h0;
`endif
        end else if (req_accepted) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (redirect_valid) begin
          // The in-flight word belongs to the old path; drop it now or when it arrives.
          discard_d = !iresp_data_ok;
          if (iresp_data_ok) begin
            state_d = StReq;
          end
        end else if (iresp_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = StReq;
          end else begin
            state_d     = StHold;
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = iresp_data;
          end
        end
      end

      StHold: begin
        if (redirect_valid || out_ready) begin
          state_d     = StReq;
          out_valid_d = 1'b0;
`ifdef FETCH_ADEL_EN
          out_adel_d  = 1'b0;
`endif
        end
      end

      default: state_d = StReq;
    endcase

`ifdef FETCH_ADEL_EN
    ireq_valid_d = (state_d == StReq) && pc_aligned(pc_d);
`else
    ireq_valid_d = (state_d == StReq);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      discard_q    <= 1'b0;
      ireq_valid_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0;
      out_instr_q  <= 32'h0;
`ifdef FETCH_ADEL_EN
      out_adel_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      discard_q    <= discard_d;
      ireq_valid_q <= ireq_valid_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
`ifdef FETCH_ADEL_EN
      out_adel_q   <= out_adel_d;
`endif
    end
  end

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = pc_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;
`ifdef FETCH_ADEL_EN
  assign out_adel   = out_adel_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected fetched words plus fixed-cycle checks
// of handshake, redirect/discard, wrap-around and reset behaviour.
module tb_fetch_unit;

  logic        clk;
  logic        resetn;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_ADEL_EN
  logic        out_adel;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  fetch_unit #(
    .RESET_PC (32'hbfc0_0000)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_addr_ok  (iresp_addr_ok),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
`ifdef FETCH_ADEL_EN
    ,
    .out_adel       (out_adel)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the presented instruction against the oldest expected entry without consuming it.
  task automatic check_out(input string tag);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (sb.size() != 0) begin
      chk({tag, "_pc"}, out_pc, sb[0].pc);
      chk({tag, "_instr"}, out_instr, sb[0].instr);
    end
  endtask

  task automatic wait_out_valid(input string tag, input int max_cycles);
    int k = 0;
    while (out_valid !== 1'b1 && k < max_cycles) begin
      step();
      k++;
    end
    chk({tag, "_wait"}, 32'(out_valid), 32'd1);
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] word,
                          input int lat);
    exp_t e;
    chk({tag, "_req_valid"}, 32'(ireq_valid), 32'd1);
    chk({tag, "_req_addr"}, ireq_addr, addr);
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    repeat (lat) step();
    iresp_data_ok = 1'b1;
    iresp_data    = word;
    e.pc          = addr;
    e.instr       = word;
    sb.push_back(e);
    step();
    iresp_data_ok = 1'b0;
    wait_out_valid(tag, 4);
    check_out(tag);
  endtask

  task automatic drop_held();
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  initial begin
    resetn         = 1'b1;
    iresp_addr_ok  = 1'b0;
    iresp_data_ok  = 1'b0;
    iresp_data     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    #1 resetn = 1'b0;
    #2;
    chk("rst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_pc", ireq_addr, 32'hbfc0_0000);
    #19 resetn = 1'b1;

    // Reset release, addr_ok cycle 1, data_ok cycle 3, out_valid cycle 4.
    step();
    chk("c1_req_valid", 32'(ireq_valid), 32'd1);
    chk("c1_req_addr", ireq_addr, 32'hbfc0_0000);
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    chk("c2_wait_no_req", 32'(ireq_valid), 32'd0);
    chk("c2_no_out", 32'(out_valid), 32'd0);
    step();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2408_0001;
    sb.push_back('{pc: 32'hbfc0_0000, instr: 32'h2408_0001});
    step();
    iresp_data_ok = 1'b0;
    check_out("c4_first");

    // Stall in HOLD; stray data_ok must be ignored.
    for (int i = 0; i < 5; i++) begin
      iresp_data_ok = (i == 2);
      iresp_data    = 32'hffff_ffff;
      step();
      iresp_data_ok = 1'b0;
      check_out("hold_stall");
      chk("hold_no_req", 32'(ireq_valid), 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drop_held();
    chk("consume_out_valid", 32'(out_valid), 32'd0);
    chk("consume_req_valid", 32'(ireq_valid), 32'd1);
    chk("consume_next_addr", ireq_addr, 32'hbfc0_0004);

    // data_ok in REQ ignored; redirect in REQ without addr_ok.
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h1111_1111;
    step();
    iresp_data_ok = 1'b0;
    chk("req_dataok_ignored", 32'(out_valid), 32'd0);
    chk("req_addr_held", ireq_addr, 32'hbfc0_0004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0040;
    step();
    redirect_valid = 1'b0;
    chk("req_redir_addr", ireq_addr, 32'hbfc0_0040);
    chk("req_redir_valid", 32'(ireq_valid), 32'd1);

    // Redirect in WAIT, stale data two cycles later.
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0100;
    step();
    redirect_valid = 1'b0;
    step();
    iresp_data_ok = 1'b1;
    iresp_data    = 32'hdead_beef;
    step();
    iresp_data_ok = 1'b0;
    chk("wait_redir_no_out", 32'(out_valid), 32'd0);
    chk("wait_redir_req", 32'(ireq_valid), 32'd1);
    chk("wait_redir_addr", ireq_addr, 32'hbfc0_0100);
    step();
    chk("wait_redir_still_no_out", 32'(out_valid), 32'd0);
    do_fetch("after_redir", 32'hbfc0_0100, 32'h8c82_0000, 0);

    // Redirect with out_ready in HOLD: redirect wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0200;
    out_ready      = 1'b1;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    drop_held();
    chk("hold_redir_out_valid", 32'(out_valid), 32'd0);
    chk("hold_redir_req", 32'(ireq_valid), 32'd1);
    chk("hold_redir_addr", ireq_addr, 32'hbfc0_0200);

    // Redirect together with addr_ok in REQ.
    iresp_addr_ok  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0300;
    step();
    iresp_addr_ok  = 1'b0;
    redirect_valid = 1'b0;
    chk("req_redir_ack_wait", 32'(ireq_valid), 32'd0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h2222_2222;
    step();
    iresp_data_ok = 1'b0;
    chk("req_redir_ack_no_out", 32'(out_valid), 32'd0);
    chk("req_redir_ack_addr", ireq_addr, 32'hbfc0_0300);

    // Redirect and data_ok in the same WAIT cycle.
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0400;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'h3333_3333;
    step();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    chk("wait_redir_data_no_out", 32'(out_valid), 32'd0);
    chk("wait_redir_data_addr", ireq_addr, 32'hbfc0_0400);
    chk("wait_redir_data_req", 32'(ireq_valid), 32'd1);

    // Back-to-back redirects: the latest one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0500;
    step();
    redirect_pc = 32'hbfc0_0600;
    step();
    redirect_valid = 1'b0;
    chk("b2b_req_addr", ireq_addr, 32'hbfc0_0600);
    iresp_addr_ok  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0700;
    step();
    iresp_addr_ok = 1'b0;
    redirect_pc   = 32'hbfc0_0800;
    step();
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b1;
    iresp_data     = 32'h4444_4444;
    step();
    iresp_data_ok = 1'b0;
    chk("b2b_no_out", 32'(out_valid), 32'd0);
    chk("b2b_addr", ireq_addr, 32'hbfc0_0800);
    do_fetch("b2b_fetch", 32'hbfc0_0800, 32'h3c1d_0000, 2);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drop_held();
    chk("b2b_next_addr", ireq_addr, 32'hbfc0_0804);

    // PC wrap-around.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    step();
    redirect_valid = 1'b0;
    do_fetch("wrap", 32'hffff_fffc, 32'h27bd_fff8, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    drop_held();
    chk("wrap_addr", ireq_addr, 32'h0000_0000);
    chk("wrap_req", 32'(ireq_valid), 32'd1);

    // Misaligned redirect target.
    do_fetch("pre_misalign", 32'h0000_0000, 32'h1234_5678, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0002;
    step();
    redirect_valid = 1'b0;
    drop_held();
`ifdef FETCH_ADEL_EN
    chk("adel_no_req", 32'(ireq_valid), 32'd0);
    chk("adel_pre_out", 32'(out_valid), 32'd0);
    step();
    chk("adel_out_valid", 32'(out_valid), 32'd1);
    chk("adel_flag", 32'(out_adel), 32'd1);
    chk("adel_instr", out_instr, 32'h0);
    chk("adel_pc", out_pc, 32'hbfc0_0002);
    chk("adel_still_no_req", 32'(ireq_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0500;
    step();
    redirect_valid = 1'b0;
    chk("adel_clear", 32'(out_adel), 32'd0);
    chk("adel_exit_out", 32'(out_valid), 32'd0);
`else
    chk("misalign_req", 32'(ireq_valid), 32'd1);
    chk("misalign_addr", ireq_addr, 32'hbfc0_0002);
    chk("misalign_no_out", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hbfc0_0500;
    step();
    redirect_valid = 1'b0;
`endif
    chk("realign_req", 32'(ireq_valid), 32'd1);
    chk("realign_addr", ireq_addr, 32'hbfc0_0500);

    // Reset mid-transaction with a late data_ok afterwards.
    iresp_addr_ok = 1'b1;
    step();
    iresp_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_req", 32'(ireq_valid), 32'd0);
    chk("midrst_out", 32'(out_valid), 32'd0);
    chk("midrst_pc", ireq_addr, 32'hbfc0_0000);
    chk("midrst_instr", out_instr, 32'h0);
    iresp_data_ok = 1'b1;
    iresp_data    = 32'h5555_5555;
    @(posedge clk);
    #4 resetn = 1'b1;
    step();
    chk("late_data_req", 32'(ireq_valid), 32'd1);
    chk("late_data_no_out", 32'(out_valid), 32'd0);
    iresp_data_ok = 1'b0;
    step();
    chk("late_data_still_no_out", 32'(out_valid), 32'd0);
    do_fetch("post_rst", 32'hbfc0_0000, 32'h2408_0001, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
